breakout_game_ctrl: RTL and testbench

Top-level game sequencer for the breakout design. It sits between the VGA timing generator, the paddle/ball/brick logic and the board I/O. It gates motion, serves the ball, tracks lives and a BCD score, and declares win or game-over. All game datapath blocks take their run/reset strobes from this block.

---
 rtl/breakout_game_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: frame timing, start debounce, serve/play/miss
// flow, lives bookkeeping and a saturating 4-digit BCD score.
module breakout_game_ctrl #(
    parameter int LIVES           = 3,
    parameter int SERVE_FRAMES    = 60,
    parameter int POINTS          = 1,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        start_n,
    input  logic        ball_lost,
    input  logic        brick_hit,
    input  logic        all_bricks_gone,
    output logic        game_run,
    output logic        ball_reset,
    output logic        bricks_reset,
    output logic        frame_tick,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [2:0]  state,
    output logic        win,
    output logic        lose
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        MISS     = 3'd3,
        WIN      = 3'd4,
        GAMEOVER = 3'd5
    } state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          vs_s1, vs_s2, vs_d;
    logic          st_s1, st_s2;
    logic [DW-1:0] deb_cnt;
    logic          deb_fired;
    logic          press;
    logic          bl_d;
    logic          loss;

    state_t        state_q, state_d;
    logic [1:0]    lives_d;
    logic [15:0]   score_d;
    logic [7:0]    serve_cnt, serve_cnt_d;
    logic          ball_reset_d, bricks_reset_d;

    // Saturating BCD increment by POINTS; a carry out of digit 3 pins the score at 9999.
    function automatic logic [15:0] bcd_add(input logic [15:0] a);
        logic [15:0] r;
        logic [4:0]  d;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + ((i == 0) ? 5'(POINTS) : 5'd0) + {4'd0, c};
            if (d > 5'd9) begin
                r[4*i +: 4] = 4'(d - 5'd10);
                c = 1'b1;
            end else begin
                r[4*i +: 4] = d[3:0];
                c = 1'b0;
            end
        end
        return c ? 16'h9999 : r;
    endfunction

    // Bring vsync into the clock domain and remember the previous synchronized level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
        end
    end

    assign frame_tick = vs_d & ~vs_s2;

    // Synchronize the start key and raise one press pulse per debounced low period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_s1     <= 1'b0;
            st_s2     <= 1'b0;
            deb_cnt   <= '0;
            deb_fired <= 1'b0;
            press     <= 1'b0;
        end else begin
            st_s1 <= start_n;
            st_s2 <= st_s1;
            press <= 1'b0;
            if (st_s2) begin
                deb_cnt   <= '0;
                deb_fired <= 1'b0;
            end else if (!deb_fired) begin
                if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    press     <= 1'b1;
                    deb_fired <= 1'b1;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end
    end

    // Track ball_lost so only its rising edge counts as a loss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bl_d <= 1'b0;
        else      bl_d <= ball_lost;
    end

    assign loss = ball_lost & ~bl_d;

    // Next-state, lives, score and serve-counter decisions.
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d        = state_q;
        lives_d        = lives;
        score_d        = score;
        serve_cnt_d    = serve_cnt;
        ball_reset_d   = 1'b0;
        bricks_reset_d = 1'b0;
        case (state_q)
            IDLE, WIN, GAMEOVER: begin
                if (press) begin
                    ball_reset_d   = 1'b1;
                    bricks_reset_d = 1'b1;
                    lives_d        = 2'(LIVES);
                    score_d        = '0;
                    serve_cnt_d    = '0;
                    state_d        = SERVE;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (serve_cnt == 8'(SERVE_FRAMES - 1)) begin
                        serve_cnt_d = '0;
                        state_d     = PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (brick_hit) score_d = bcd_add(score);
                if (all_bricks_gone) state_d = WIN;
                else if (loss)       state_d = MISS;
            end
            MISS: begin
                if (lives == 2'd1) begin
                    lives_d = 2'd0;
                    state_d = GAMEOVER;
                end else begin
                    lives_d      = lives - 1'b1;
                    ball_reset_d = 1'b1;
                    serve_cnt_d  = '0;
                    state_d      = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Game state register; status outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lives        <= 2'(LIVES);
            score        <= '0;
            serve_cnt    <= '0;
            ball_reset   <= 1'b0;
            bricks_reset <= 1'b0;
            game_run     <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives        <= lives_d;
            score        <= score_d;
            serve_cnt    <= serve_cnt_d;
            ball_reset   <= ball_reset_d;
            bricks_reset <= bricks_reset_d;
            game_run     <= (state_d == PLAY);
            win          <= (state_d == WIN);
            lose         <= (state_d == GAMEOVER);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl with short debounce and serve times.
module tb_breakout_game_ctrl;

    localparam int LIVES = 3;
    localparam int SERVE_FRAMES = 3;
    localparam int POINTS = 5;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst, vsync, start_n, ball_lost, brick_hit, all_bricks_gone;
    logic game_run, ball_reset, bricks_reset, frame_tick, win, lose;
    logic [1:0] lives;
    logic [15:0] score;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail = 0;
    int br_cnt = 0, bl_cnt = 0, ft_cnt = 0;
    int exp_score = 0;

    breakout_game_ctrl #(
        .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .POINTS(POINTS), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .start_n(start_n), .ball_lost(ball_lost),
        .brick_hit(brick_hit), .all_bricks_gone(all_bricks_gone), .game_run(game_run),
        .ball_reset(ball_reset), .bricks_reset(bricks_reset), .frame_tick(frame_tick),
        .lives(lives), .score(score), .state(state), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bricks_reset) br_cnt++;
        if (ball_reset)   bl_cnt++;
        if (frame_tick)   ft_cnt++;
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int sat_add(input int v);
        return (v + POINTS > 9999) ? 9999 : v + POINTS;
    endfunction

    task automatic wait_negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_frame();
        vsync = 1'b0;
        wait_negs(3);
        vsync = 1'b1;
        wait_negs(5);
    endtask

    task automatic do_press();
        start_n = 1'b0;
        wait_negs(10);
        start_n = 1'b1;
        wait_negs(4);
    endtask

    task automatic lose_ball();
        ball_lost = 1'b1;
        wait_negs(1);
        ball_lost = 1'b0;
        wait_negs(3);
    endtask

    task automatic hit_once();
        brick_hit = 1'b1;
        wait_negs(1);
        brick_hit = 1'b0;
        wait_negs(1);
    endtask

    task automatic restart_game();
        rst = 1'b0;
        wait_negs(2);
        rst = 1'b1;
        wait_negs(2);
        do_press();
        repeat (SERVE_FRAMES) do_frame();
        exp_score = 0;
    endtask

    task automatic test_reset();
        int b0, l0, f0;
        rst = 1'b0;
        wait_negs(3);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", lives); end
        n_checks++; if ({game_run, win, lose, ball_reset, bricks_reset, frame_tick} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 000000", {game_run, win, lose, ball_reset, bricks_reset, frame_tick}); end
        rst = 1'b1;
        wait_negs(2);
        do_press();
        repeat (SERVE_FRAMES) do_frame();
        hit_once();
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL pre_reset_play: got %0d want 2", state); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({state, lives, score, game_run} !== {3'd0, 2'd3, 16'h0000, 1'b0}) begin
            n_fail++; $display("FAIL async_reset: got state=%0d lives=%0d score=%h run=%b want 0/3/0000/0", state, lives, score, game_run); end
        wait_negs(2);
        rst = 1'b1;
        wait_negs(2);
        b0 = br_cnt; l0 = bl_cnt; f0 = ft_cnt;
        repeat (10) do_frame();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", state); end
        n_checks++; if ((br_cnt - b0) + (bl_cnt - l0) !== 0) begin
            n_fail++; $display("FAIL idle_pulses: got %0d want 0", (br_cnt - b0) + (bl_cnt - l0)); end
        n_checks++; if (ft_cnt - f0 !== 10) begin n_fail++; $display("FAIL idle_frames: got %0d want 10", ft_cnt - f0); end
    endtask

    task automatic test_start_serve();
        int b0, f0;
        bit seen;
        b0 = br_cnt;
        start_n = 1'b0;
        wait_negs(3);
        start_n = 1'b1;
        wait_negs(8);
        n_checks++; if ((br_cnt - b0) !== 0 || state !== 3'd0) begin
            n_fail++; $display("FAIL short_press: got pulses=%0d state=%0d want 0/0", br_cnt - b0, state); end
        start_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bricks_reset) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL press_event: got none want bricks_reset pulse"); end
        n_checks++; if ({ball_reset, state} !== {1'b1, 3'd1}) begin
            n_fail++; $display("FAIL press_outputs: got ball_reset=%b state=%0d want 1/1", ball_reset, state); end
        wait_negs(1);
        n_checks++; if ({bricks_reset, ball_reset} !== 2'b00) begin
            n_fail++; $display("FAIL pulse_width: got %b want 00", {bricks_reset, ball_reset}); end
        wait_negs(30);
        start_n = 1'b1;
        wait_negs(4);
        n_checks++; if (br_cnt - b0 !== 1) begin n_fail++; $display("FAIL single_event: got %0d want 1", br_cnt - b0); end
        f0 = ft_cnt;
        do_frame();
        do_frame();
        n_checks++; if ({state, game_run} !== {3'd1, 1'b0}) begin
            n_fail++; $display("FAIL serve_hold: got state=%0d run=%b want 1/0", state, game_run); end
        do_frame();
        n_checks++; if ({state, game_run} !== {3'd2, 1'b1}) begin
            n_fail++; $display("FAIL serve_done: got state=%0d run=%b want 2/1", state, game_run); end
        n_checks++; if (ft_cnt - f0 !== 3) begin n_fail++; $display("FAIL serve_ticks: got %0d want 3", ft_cnt - f0); end
    endtask

    task automatic test_scoring();
        exp_score = 0;
        repeat (3) begin hit_once(); exp_score = sat_add(exp_score); end
        n_checks++; if (score !== 16'h0015) begin n_fail++; $display("FAIL score_three: got %h want 0015", score); end
        brick_hit = 1'b1;
        for (int i = 0; i < 1996; i++) begin
            @(negedge clk);
            exp_score = sat_add(exp_score);
        end
        brick_hit = 1'b0;
        wait_negs(1);
        n_checks++; if (score !== to_bcd(exp_score)) begin n_fail++; $display("FAIL score_9995: got %h want %h", score, to_bcd(exp_score)); end
        hit_once();
        exp_score = sat_add(exp_score);
        n_checks++; if (score !== 16'h9999) begin n_fail++; $display("FAIL score_sat: got %h want 9999", score); end
        hit_once();
        n_checks++; if (score !== to_bcd(exp_score)) begin n_fail++; $display("FAIL score_sat_hold: got %h want %h", score, to_bcd(exp_score)); end
        lose_ball();
        n_checks++; if ({state, lives} !== {3'd1, 2'd2}) begin
            n_fail++; $display("FAIL miss_to_serve: got state=%0d lives=%0d want 1/2", state, lives); end
        hit_once();
        n_checks++; if (score !== 16'h9999) begin n_fail++; $display("FAIL serve_hit: got %h want 9999", score); end
    endtask

    task automatic test_lives();
        int l0;
        restart_game();
        l0 = bl_cnt;
        ball_lost = 1'b1;
        wait_negs(100);
        n_checks++; if ({lives, state} !== {2'd2, 3'd1}) begin
            n_fail++; $display("FAIL held_loss: got lives=%0d state=%0d want 2/1", lives, state); end
        n_checks++; if (bl_cnt - l0 !== 1) begin n_fail++; $display("FAIL miss_ball_reset: got %0d want 1", bl_cnt - l0); end
        ball_lost = 1'b0;
        repeat (SERVE_FRAMES) do_frame();
        n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL reserve_play: got %0d want 2", state); end
        lose_ball();
        n_checks++; if ({lives, state} !== {2'd1, 3'd1}) begin
            n_fail++; $display("FAIL second_loss: got lives=%0d state=%0d want 1/1", lives, state); end
        repeat (SERVE_FRAMES) do_frame();
        lose_ball();
        n_checks++; if ({state, lives, lose, win, game_run} !== {3'd5, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL gameover: got state=%0d lives=%0d lose=%b win=%b run=%b want 5/0/1/0/0", state, lives, lose, win, game_run); end
    endtask

    task automatic test_restart(input string tag);
        int b0, l0;
        b0 = br_cnt; l0 = bl_cnt;
        do_press();
        n_checks++; if ((br_cnt - b0) !== 1 || (bl_cnt - l0) !== 1) begin
            n_fail++; $display("FAIL %s_pulses: got bricks=%0d ball=%0d want 1/1", tag, br_cnt - b0, bl_cnt - l0); end
        n_checks++; if ({state, lives, score, win, lose} !== {3'd1, 2'd3, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL %s_state: got state=%0d lives=%0d score=%h win=%b lose=%b want 1/3/0000/0/0", tag, state, lives, score, win, lose); end
    endtask

    task automatic test_win_priority();
        repeat (SERVE_FRAMES) do_frame();
        all_bricks_gone = 1'b1;
        ball_lost = 1'b1;
        brick_hit = 1'b1;
        wait_negs(1);
        brick_hit = 1'b0;
        ball_lost = 1'b0;
        wait_negs(2);
        n_checks++; if ({state, win, lose, lives, game_run} !== {3'd4, 1'b1, 1'b0, 2'd3, 1'b0}) begin
            n_fail++; $display("FAIL win_state: got state=%0d win=%b lose=%b lives=%0d run=%b want 4/1/0/3/0", state, win, lose, lives, game_run); end
        n_checks++; if (score !== to_bcd(POINTS)) begin n_fail++; $display("FAIL win_score: got %h want %h", score, to_bcd(POINTS)); end
        hit_once();
        n_checks++; if (score !== to_bcd(POINTS)) begin n_fail++; $display("FAIL win_hold: got %h want %h", score, to_bcd(POINTS)); end
        all_bricks_gone = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        vsync = 1'b1;
        start_n = 1'b1;
        ball_lost = 1'b0;
        brick_hit = 1'b0;
        all_bricks_gone = 1'b0;
        test_reset();
        test_start_serve();
        test_scoring();
        test_lives();
        test_restart("restart_gameover");
        test_win_priority();
        test_restart("restart_win");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
